sharpen_window_gen: RTL
=======================

Name: sharpen_window_gen

Overview:
- Streaming 3x3 window generator placed directly upstream of the sharpening convolution stage.
- Accepts a raster-order pixel stream and keeps two line buffers plus a 3x3 shift window.
- Emits one complete 3x3 neighbourhood per interior pixel, so the sharpening stage sees a ready-made in_image window every handshake.
- Handshake is valid/ready on both sides; throughput is 1 pixel/cycle when not back-pressured.

Parameters:
- IMG_W, 512, pixels per line (>=3)
- IMG_H, 512, lines per frame (>=3)
- PIX_W, 8, bits per pixel

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- in_valid  in  1  upstream pixel valid
- in_ready  out  1  block can accept a pixel this cycle
- in_pixel  in  PIX_W  pixel, raster order, row 0 col 0 first
- out_valid  out  1  out_window holds a valid window
- out_ready  in  1  downstream accepts the window
- out_window  out  3x3xPIX_W  [row][col]; [0][*] is top line, [*][0] is left column
- out_row  out  $clog2(IMG_H)  row of the window centre pixel
- out_col  out  $clog2(IMG_W)  column of the window centre pixel
- out_last  out  1  window is the last one of the frame (centre = IMG_H-2, IMG_W-2)
- frame_done  out  1  one-cycle pulse when the out_last window is handshaken

Behaviour:
- Reset (reset=0, async): out_valid=0, out_window=0, out_row=0, out_col=0, out_last=0, frame_done=0; col/row counters=0. in_ready=1 once reset is released. Line-buffer RAM contents are not cleared.
- Accept condition: in_valid && in_ready. in_ready = !out_valid || out_ready. This is a single output register with no skid buffer.
- On accept of pixel (r,c):
  - Read lb0[c], which is pixel (r-1,c), and lb1[c], which is pixel (r-2,c).
  - Write lb1[c]<=old lb0[c] and lb0[c]<=in_pixel. Read-before-write at the same address is required.
  - Shift the window left one column; the new right column is {lb1[c], lb0[c], in_pixel} (top to bottom).
- Window emit: if r>=2 and c>=2 on accept, the next cycle has out_valid=1, out_row=r-1, out_col=c-1, and out_last=(r==IMG_H-1 && c==IMG_W-1). Latency is exactly 1 cycle.
- Non-emitting accepts (r<2 or c<2) update the buffers only. out_valid is cleared if the previous window was handshaken in that cycle.
- Hold: while out_valid && !out_ready, all outputs stay stable and no pixel is accepted.
- Simultaneous events: an output handshake plus an input accept in the same cycle is legal and gives full throughput.
- Counters:
  - c increments per accept and wraps IMG_W-1 -> 0 with r++.
  - After (IMG_H-1, IMG_W-1), r and c return to 0,0 and the next frame starts immediately.
  - Stale line-buffer data never reaches the output, because emission needs r>=2.
- Window count per frame is (IMG_W-2)*(IMG_H-2). Border pixels get no window.
- frame_done: asserted for exactly the cycle after the out_last handshake.
- Mid-frame reset: the partial frame is abandoned and the next accepted pixel is treated as (0,0).
- Arithmetic: pure data movement, no pixel arithmetic. Counter widths must hold IMG_W-1 and IMG_H-1.

Decomposition:
- Package sharpen_pkg:
  - pixel_t = logic [PIX_W-1:0]
  - window_t = pixel_t [3][3]
  - default IMG_W/IMG_H/PIX_W constants, shared with the sharpening stage.
- Sub-module sharpen_line_buffer:
  - depth IMG_W, one read and one write at the same address per cycle, read-before-write.
  - Instantiated twice (lb0, lb1).
- Window shift register and counters stay in the top module.

Test Plan (IMG_W=8, IMG_H=6, pixel = (r*8+c) mod 256 unless noted):
- Stream 48 pixels with out_ready=1 -> first out_valid one cycle after accept #19.
  - Window {{0,1,2},{8,9,10},{16,17,18}}, out_row=1, out_col=1.
  - Exactly 24 windows in total; the last has centre (4,6), out_last=1, and is followed by a one-cycle frame_done.
- Row-start gap: accepts of (3,0) and (3,1) -> no out_valid. Accept of (3,2) -> window {{8,9,10},{16,17,18},{24,25,26}}, out_row=2, out_col=1.
- Backpressure: hold out_ready=0 for 5 cycles while a window is valid.
  - in_ready=0 and out_window/out_row/out_col remain constant throughout.
  - On release, the next pixel is accepted in the same cycle and no window is lost or duplicated (24 total).
- Random in_valid/out_ready (50% each, 3 frames back-to-back, second frame pixel = 255-(r*8+c)) -> 72 windows in order. Every window matches the reference model, and frame_done pulses 3 times.
- Assert reset=0 for 2 cycles after 30 pixels, then stream a full frame.
  - During reset: out_valid=0 and frame_done=0.
  - After reset, the first window appears after accept #19 of the new stream, with correct values.

Source files
------------

// File: rtl/sharpen_pkg.sv
// Shared definitions for the sharpening front end.
// Holds the default frame geometry and pixel width, the pixel and 3x3 window
// types, and a width helper used to size the raster counters. The sharpening
// stage imports the same package so both sides agree on the window layout.
package sharpen_pkg;

  localparam int DEF_IMG_W = 512;
  localparam int DEF_IMG_H = 512;
  localparam int DEF_PIX_W = 8;
  localparam int WIN_N     = 3;

  typedef logic [DEF_PIX_W-1:0] pixel_t;
  // Indexed [row][col]; [0][*] is the top line, [*][0] the left column.
  typedef pixel_t [WIN_N-1:0][WIN_N-1:0] window_t;

  // Counter width able to hold n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sharpen_window_gen_if.sv
// Stream interface of the 3x3 window generator.
// Input side : in_valid / in_ready / in_pixel (raster-order pixels).
// Output side: out_valid / out_ready / out_window / out_row / out_col /
//              out_last, plus the frame_done pulse.
// slave  : view taken by the window generator.
// master : view taken by the producer/consumer pair around it.
interface sharpen_window_gen_if #(
  parameter int PIX_W = 8,
  parameter int ROW_W = 9,
  parameter int COL_W = 9
);

  logic                            in_valid;
  logic                            in_ready;
  logic [PIX_W-1:0]                in_pixel;
  logic                            out_valid;
  logic                            out_ready;
  logic [2:0][2:0][PIX_W-1:0]      out_window;
  logic [ROW_W-1:0]                out_row;
  logic [COL_W-1:0]                out_col;
  logic                            out_last;
  logic                            frame_done;

  modport slave (
    input  in_valid, in_pixel, out_ready,
    output in_ready, out_valid, out_window, out_row, out_col, out_last,
           frame_done
  );

  modport master (
    output in_valid, in_pixel, out_ready,
    input  in_ready, out_valid, out_window, out_row, out_col, out_last,
           frame_done
  );

endinterface

// File: rtl/sharpen_line_buffer.sv
// One-line pixel buffer for the window generator.
// Ports:
//   clk      : clock
//   i_we     : write enable (one pixel accepted this cycle)
//   i_addr   : column address, shared by the read and the write
//   i_wdata  : pixel written at i_addr on the rising edge
//   o_rdata  : pixel currently stored at i_addr
// The read is combinational from the array, so it returns the old contents
// in the same cycle the new value is being written (read-before-write).
// Contents are never cleared; the generator only emits once they are valid.
module sharpen_line_buffer #(
  parameter int DEPTH = 512,
  parameter int PIX_W = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [PIX_W-1:0]  i_wdata,
  output logic [PIX_W-1:0]  o_rdata
);

  logic [PIX_W-1:0] r_mem [DEPTH];

  assign o_rdata = r_mem[i_addr];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

endmodule

// File: rtl/sharpen_window_gen.sv
// Streaming 3x3 window generator feeding the sharpening convolution.
// Ports:
//   clk   : clock, all logic on the rising edge
//   reset : asynchronous, active-low reset
//   bus   : slave view of sharpen_window_gen_if
//           in_valid/in_ready/in_pixel   raster-order pixel input
//           out_valid/out_ready          window handshake
//           out_window                   [row][col] neighbourhood
//           out_row/out_col              centre pixel coordinates
//           out_last                     last window of the frame
//           frame_done                   pulse after the out_last handshake
// Two line buffers hold the previous two lines; a 3x3 shift register slides
// one column per accepted pixel. A window is emitted for every interior
// centre pixel, one cycle after the pixel completing it is accepted.
module sharpen_window_gen
  import sharpen_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int PIX_W = DEF_PIX_W
) (
  input  logic                 clk,
  input  logic                 reset,
  sharpen_window_gen_if.slave  bus
);

  localparam int COL_W = cnt_w(IMG_W);
  localparam int ROW_W = cnt_w(IMG_H);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] ONE_C    = COL_W'(1);
  localparam logic [ROW_W-1:0] ONE_R    = ROW_W'(1);
  localparam logic [COL_W-1:0] TWO_C    = COL_W'(2);
  localparam logic [ROW_W-1:0] TWO_R    = ROW_W'(2);

  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;

  logic                       r_vld_p1;
  logic [2:0][2:0][PIX_W-1:0] r_win_p1;
  logic [ROW_W-1:0]           r_row_p1;
  logic [COL_W-1:0]           r_col_p1;
  logic                       r_last_p1;
  logic                       r_done_p2;

  logic             w_in_ready;
  logic             w_acc;
  logic             w_hs;
  logic             w_emit;
  logic [PIX_W-1:0] w_lb0_rd;
  logic [PIX_W-1:0] w_lb1_rd;

  // Single output register, no skid: a new pixel may enter only when the
  // held window is empty or leaving this cycle.
  assign w_in_ready = !r_vld_p1 || bus.out_ready;
  assign w_acc      = bus.in_valid && w_in_ready;
  assign w_hs       = r_vld_p1 && bus.out_ready;
  assign w_emit     = w_acc && (r_row >= TWO_R) && (r_col >= TWO_C);

  // lb0 holds line r-1, lb1 holds line r-2. On accept lb1 takes the old lb0
  // value so both lines advance together at the same column address.
  sharpen_line_buffer #(.DEPTH(IMG_W), .PIX_W(PIX_W), .ADDR_W(COL_W)) u_lb0 (
    .clk     (clk),
    .i_we    (w_acc),
    .i_addr  (r_col),
    .i_wdata (bus.in_pixel),
    .o_rdata (w_lb0_rd)
  );

  sharpen_line_buffer #(.DEPTH(IMG_W), .PIX_W(PIX_W), .ADDR_W(COL_W)) u_lb1 (
    .clk     (clk),
    .i_we    (w_acc),
    .i_addr  (r_col),
    .i_wdata (w_lb0_rd),
    .o_rdata (w_lb1_rd)
  );

  // Raster position of the next pixel; wraps to (0,0) so the next frame
  // starts immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_acc) begin
      if (r_col == LAST_COL) begin
        r_col <= '0;
        r_row <= (r_row == LAST_ROW) ? '0 : r_row + ONE_R;
      end else begin
        r_col <= r_col + ONE_C;
      end
    end
  end

  // ---- stage p1: window shift register (also the output window) ----
  // Shifts only on accept, and accept is blocked while a window is held,
  // so the presented window stays stable under back-pressure.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_win_p1 <= '0;
    end else if (w_acc) begin
      for (int i = 0; i < 3; i++) begin
        r_win_p1[i][0] <= r_win_p1[i][1];
        r_win_p1[i][1] <= r_win_p1[i][2];
      end
      r_win_p1[0][2] <= w_lb1_rd;
      r_win_p1[1][2] <= w_lb0_rd;
      r_win_p1[2][2] <= bus.in_pixel;
    end
  end

  // ---- stage p1: output valid and window coordinates ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld_p1  <= 1'b0;
      r_row_p1  <= '0;
      r_col_p1  <= '0;
      r_last_p1 <= 1'b0;
    end else if (w_emit) begin
      r_vld_p1  <= 1'b1;
      r_row_p1  <= r_row - ONE_R;
      r_col_p1  <= r_col - ONE_C;
      r_last_p1 <= (r_row == LAST_ROW) && (r_col == LAST_COL);
    end else if (w_hs) begin
      r_vld_p1  <= 1'b0;
    end
  end

  // ---- stage p2: end-of-frame pulse ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_done_p2 <= 1'b0;
    end else begin
      r_done_p2 <= w_hs && r_last_p1;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_vld_p1;
  assign bus.out_window = r_win_p1;
  assign bus.out_row    = r_row_p1;
  assign bus.out_col    = r_col_p1;
  assign bus.out_last   = r_last_p1;
  assign bus.frame_done = r_done_p2;

endmodule
